unified_mem_arbiter: RTL and testbench

Arbiter and sequencer for a single-port unified instruction/data memory shared by the pipeline's fetch stage and its memory stage. It grants one access at a time and drives the memory port. It returns read data and completion to the owning requester, and produces per-requester stall signals that freeze the pipeline until each access completes. It sits between the IF/MEM stages, where the decoder's MemRead/MemWrite feed the data request, and the memory macro.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_lat_counter.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 9;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; tracks cycles until memory read data is valid.
module mem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter: data stage has priority over fetch.
// Optional fetch starvation guard enabled by defining ARB_FAIRNESS_EN.
//
// state | meaning
// IDLE  | no access outstanding; a request present is granted this cycle
// WAIT  | access issued, counting down to the cycle mem_rdata is valid
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_rvalid,
    output logic                if_stall,
    input  logic                d_rd,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_stall,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int              CNT_W    = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_e state, state_nxt;
    arb_owner_e owner, owner_nxt;
    logic       own_wr, own_wr_nxt;
    logic       data_req, fetch_force;
    logic       gnt_data, gnt_fetch;
    logic       lat_zero, done;

    assign data_req = d_rd | d_wr;

`ifdef ARB_FAIRNESS_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    // Only data grants that beat a waiting fetch count; the counter never passes STARVE_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (gnt_fetch) begin
            starve_cnt <= '0;
        end else if (gnt_data && if_req) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign fetch_force = if_req && (starve_cnt >= SC_W'(STARVE_MAX));
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX > 0);
    assign fetch_force       = 1'b0;
`endif

    // Grants are purely combinational so an ungranted request is never latched.
    always_comb begin
        gnt_data  = (state == IDLE) && !reset && data_req && !fetch_force;
        gnt_fetch = (state == IDLE) && !reset && if_req && !gnt_data;
    end

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gnt_data | gnt_fetch),
        .load_val (LAT_LOAD),
        .dec      (state == WAIT),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= NONE;
            own_wr <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            own_wr <= own_wr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        own_wr_nxt = own_wr;
        case (state)
            IDLE: begin
                if (gnt_data) begin
                    state_nxt  = WAIT;
                    owner_nxt  = DATA;
                    own_wr_nxt = d_wr;
                end else if (gnt_fetch) begin
                    state_nxt  = WAIT;
                    owner_nxt  = FETCH;
                    own_wr_nxt = 1'b0;
                end
            end
            WAIT: begin
                if (lat_zero) begin
                    state_nxt  = IDLE;
                    owner_nxt  = NONE;
                    own_wr_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = NONE;
            end
        endcase
    end

    assign done = (state == WAIT) && lat_zero && !reset;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        if (gnt_data) begin
            mem_en   = 1'b1;
            mem_we   = d_wr;
            mem_addr = d_addr;
            if (d_wr) begin
                mem_wdata = d_wdata;
                mem_wstrb = d_wstrb;
            end
        end else if (gnt_fetch) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
        if (done && (owner == FETCH)) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
        end
        if (done && (owner == DATA)) begin
            d_ack   = 1'b1;
            d_rdata = own_wr ? '0 : mem_rdata;
        end
    end

    assign if_stall = if_req & ~if_rvalid;
    assign d_stall  = (d_rd | d_wr) & ~d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_unified_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // DUT0 (MEM_LAT=2)
    logic          reset, if_req, if_rvalid, if_stall, d_rd, d_wr, d_ack, d_stall, mem_en, mem_we;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [SW-1:0] d_wstrb, mem_wstrb;

    // DUT1 (MEM_LAT=1)
    logic          reset_1, if_req_1, if_rvalid_1, if_stall_1, d_rd_1, d_wr_1, d_ack_1, d_stall_1;
    logic          mem_en_1, mem_we_1;
    logic [AW-1:0] if_addr_1, d_addr_1, mem_addr_1;
    logic [DW-1:0] if_rdata_1, d_wdata_1, d_rdata_1, mem_wdata_1, mem_rdata_1;
    logic [SW-1:0] d_wstrb_1, mem_wstrb_1;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_stall(if_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset_1),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_rvalid(if_rvalid_1),
        .if_stall(if_stall_1),
        .d_rd(d_rd_1), .d_wr(d_wr_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1), .d_wstrb(d_wstrb_1),
        .d_rdata(d_rdata_1), .d_ack(d_ack_1), .d_stall(d_stall_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_wstrb(mem_wstrb_1), .mem_rdata(mem_rdata_1)
    );

    // Memory macro model: unwritten words read a fixed per-address pattern.
    logic [31:0] mem0 [int];

    function automatic logic [31:0] init_val(input int a);
        case (a)
            'h010:   return 32'h0050_0093;
            'h030:   return 32'hAAAA_AAAA;
            default: return 32'h5A5A_0000 ^ (a * 32'h0101_0101) ^ 32'h1;
        endcase
    endfunction

    function automatic logic [31:0] rd_mem(input int a);
        if (mem0.exists(a)) return mem0[a];
        return init_val(a);
    endfunction

    logic [31:0] pipe0 [2];
    logic [31:0] pipe1;
    logic [31:0] wtmp;

    always @(posedge clk) begin
        pipe0[0] <= rd_mem(int'(mem_addr));
        pipe0[1] <= pipe0[0];
        pipe1    <= rd_mem(int'(mem_addr_1));
        if (mem_en && mem_we) begin
            wtmp = rd_mem(int'(mem_addr));
            for (int b = 0; b < SW; b++)
                if (mem_wstrb[b]) wtmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem0[int'(mem_addr)] = wtmp;
        end
    end

    assign mem_rdata   = pipe0[1];
    assign mem_rdata_1 = pipe1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    exp_t sb0[$];
    exp_t sb1[$];

    exp_t e0;
    always @(negedge clk) begin
        if (if_rvalid || d_ack) begin
            if (sb0.size() == 0) begin
                chk("dut0_unexpected_pulse", {if_rvalid, d_ack}, 2'b00);
            end else begin
                e0 = sb0.pop_front();
                chk("dut0_pulse_kind", {if_rvalid, d_ack}, e0.is_data ? 2'b01 : 2'b10);
                chk("dut0_pulse_cycle", cyc, e0.cyc);
                chk("dut0_rdata", e0.is_data ? d_rdata : if_rdata, e0.data);
            end
        end
    end

    exp_t e1;
    always @(negedge clk) begin
        if (if_rvalid_1 || d_ack_1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_pulse", {if_rvalid_1, d_ack_1}, 2'b00);
            end else begin
                e1 = sb1.pop_front();
                chk("dut1_pulse_kind", {if_rvalid_1, d_ack_1}, e1.is_data ? 2'b01 : 2'b10);
                chk("dut1_pulse_cycle", cyc, e1.cyc);
                chk("dut1_rdata", e1.is_data ? d_rdata_1 : if_rdata_1, e1.data);
            end
        end
    end

    // One uncontested access on DUT0: checks the memory port at grant and stalls through completion.
    task automatic single(input string nm, input bit is_data, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [SW-1:0] st, input logic [31:0] exp_d);
        int t;
        @(posedge clk); #1;
        if (is_data) begin
            d_rd = !wr; d_wr = wr; d_addr = a; d_wdata = wd; d_wstrb = st;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        t = cyc;
        sb0.push_back('{is_data, exp_d, t + 2});
        @(negedge clk);
        chk({nm, "_mem_en"}, mem_en, 1'b1);
        chk({nm, "_mem_we"}, mem_we, wr);
        chk({nm, "_mem_addr"}, mem_addr, a);
        if (wr) begin
            chk({nm, "_mem_wdata"}, mem_wdata, wd);
            chk({nm, "_mem_wstrb"}, mem_wstrb, st);
        end
        chk({nm, "_stall_t"}, is_data ? d_stall : if_stall, 1'b1);
        @(negedge clk);
        chk({nm, "_en_one_cycle"}, {mem_en, mem_we}, 2'b00);
        chk({nm, "_stall_t1"}, is_data ? d_stall : if_stall, 1'b1);
        @(negedge clk);
        chk({nm, "_stall_done"}, is_data ? d_stall : if_stall, 1'b0);
        @(posedge clk); #1;
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        reset_1 = 1'b1; if_req_1 = 1'b0; if_addr_1 = '0; d_rd_1 = 1'b0; d_wr_1 = 1'b0;
        d_addr_1 = '0; d_wdata_1 = '0; d_wstrb_1 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_port", {mem_en, mem_we, mem_addr, mem_wstrb}, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_pulses", {if_rvalid, d_ack}, 2'b00);
        chk("rst_rdata", {if_rdata, d_rdata}, '0);
        @(posedge clk); #1;
        reset = 1'b0; reset_1 = 1'b0;

        single("fetch",      1'b0, 1'b0, 9'h010, 32'h0,         4'h0, 32'h0050_0093);
        single("store",      1'b1, 1'b1, 9'h020, 32'hDEAD_BEEF, 4'hF, 32'h0);
        single("store_strb", 1'b1, 1'b1, 9'h030, 32'h1122_3344, 4'h3, 32'h0);
        single("load_strb",  1'b1, 1'b0, 9'h030, 32'h0,         4'h0, 32'hAAAA_3344);

        // Contested: data first, fetch granted after the mandatory idle cycle.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 9'h010; d_rd = 1'b1; d_addr = 9'h020;
        t = cyc;
        sb0.push_back('{1'b1, 32'hDEAD_BEEF, t + 2});
        sb0.push_back('{1'b0, 32'h0050_0093, t + 5});
        @(negedge clk);
        chk("contest_first_addr", mem_addr, 9'h020);
        chk("contest_fetch_held", if_stall, 1'b1);
        repeat (3) @(posedge clk); #1;
        d_rd = 1'b0;
        @(negedge clk);
        chk("contest_second_grant", {mem_en, mem_addr}, {1'b1, 9'h010});
        repeat (3) @(posedge clk); #1;
        if_req = 1'b0;

        // Reset one cycle into a load: the access is dropped silently.
        @(posedge clk); #1;
        d_rd = 1'b1; d_addr = 9'h010;
        @(negedge clk);
        chk("rstmid_grant", mem_en, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; d_rd = 1'b0;
        @(negedge clk);
        chk("rstmid_during", {mem_en, d_ack}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_after_ctl", {mem_en, mem_we, d_ack, if_rvalid, d_stall}, '0);
        chk("rstmid_after_data", {d_rdata, if_rdata}, '0);
        single("post_rst_fetch", 1'b0, 1'b0, 9'h010, 32'h0, 4'h0, 32'h0050_0093);

        // MEM_LAT=1, fetch held: pulses every second cycle.
        @(posedge clk); #1;
        if_req_1 = 1'b1; if_addr_1 = 9'h010;
        t = cyc;
        for (int k = 0; k < 3; k++) sb1.push_back('{1'b0, 32'h0050_0093, t + 1 + 2 * k});
        @(negedge clk);
        chk("lat1_grant0", mem_en_1, 1'b1);
        @(negedge clk);
        chk("lat1_gap", mem_en_1, 1'b0);
        @(negedge clk);
        chk("lat1_grant1", mem_en_1, 1'b1);
        repeat (4) @(posedge clk); #1;
        if_req_1 = 1'b0;

        // Both requesters held: strict priority, or fetch on every 5th grant with fairness.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if_req = 1'b1; if_addr = 9'h010; d_rd = 1'b1; d_addr = 9'h020;
        t = cyc;
        for (int k = 0; k < 10; k++) begin
            if (FAIR && (k % 5 == 4)) sb0.push_back('{1'b0, 32'h0050_0093, t + 2 + 3 * k});
            else                      sb0.push_back('{1'b1, 32'hDEAD_BEEF, t + 2 + 3 * k});
        end
        repeat (30) @(posedge clk); #1;
        if_req = 1'b0; d_rd = 1'b0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
